// File: rtl/intr_arbiter_pkg.sv
// intr_arbiter_pkg
//   Shared types and helpers for the interrupt arbiter.
//   - arb_state_e : arbiter FSM states (IDLE -> ASSERT -> GAP -> IDLE)
//   - id_width()  : width of the source index, never narrower than 1 bit
package intr_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ASSERT = 2'd1,
    ST_GAP    = 2'd2
  } arb_state_e;

  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/intr_source_capture.sv
// intr_source_capture
//   One interrupt source: polarity normalisation, one register stage,
//   and either rising-edge capture into a sticky pending bit or a
//   pass-through level.
// Ports
//   CLK     in  clock, rising edge
//   RST     in  synchronous active-high reset
//   src     in  raw request, already synchronous to CLK
//   clr     in  one-cycle clear of the pending bit (ignored in level mode)
//   pending out pending bit for this source
module intr_source_capture #(
  parameter int C_EDGE_DETECT = 1,
  parameter int C_ACTIVE      = 1
) (
  input  logic CLK,
  input  logic RST,
  input  logic src,
  input  logic clr,
  output logic pending
);

  logic src_q, src_d;
  logic prev_q, prev_d;
  logic src_vld_q, src_vld_d;
  logic prev_vld_q, prev_vld_d;
  logic pend_q, pend_d;
  logic rise;

  // The valid pair makes sure the first post-reset sample only seeds prev_q:
  // a level held active through reset must not look like a fresh edge.
  always_comb begin
    src_d      = (C_ACTIVE != 0) ? src : ~src;
    prev_d     = src_q;
    src_vld_d  = 1'b1;
    prev_vld_d = src_vld_q;
    rise       = src_q & ~prev_q & prev_vld_q;
    // A new edge in the same cycle as the clear wins: set overrides clear.
    pend_d     = (pend_q & ~clr) | rise;
  end

  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours regardless of statement order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      src_q      <= 1'b0;
      prev_q     <= 1'b0;
      src_vld_q  <= 1'b0;
      prev_vld_q <= 1'b0;
      pend_q     <= 1'b0;
    end else begin
      src_q      <= src_d;
      prev_q     <= prev_d;
      src_vld_q  <= src_vld_d;
      prev_vld_q <= prev_vld_d;
      pend_q     <= pend_d;
    end
  end

  assign pending = (C_EDGE_DETECT != 0) ? pend_q : src_q;

endmodule

// File: rtl/intr_arbiter.sv
// intr_arbiter
//   Merges C_SOURCES interrupt requests onto one registered INTR line with
//   round-robin selection and a one-cycle low gap after every ACK.
// Ports
//   CLK      in  clock, rising edge
//   RST      in  synchronous active-high reset
//   SRC      in  [C_SOURCES] interrupt requests (polarity set by C_ACTIVE)
//   MASK     in  [C_SOURCES] 1 = source eligible for arbitration
//   ACK      in  one-cycle acknowledge of the presented interrupt
//   INTR     out merged interrupt, high only while presenting
//   INTR_ID  out index of the presented source
//   PENDING  out [C_SOURCES] raw pending bits, before masking
module intr_arbiter
  import intr_arbiter_pkg::*;
#(
  parameter int C_SOURCES     = 4,
  parameter int C_EDGE_DETECT = 1,
  parameter int C_ACTIVE      = 1
) (
  input  logic                             CLK,
  input  logic                             RST,
  input  logic [C_SOURCES-1:0]             SRC,
  input  logic [C_SOURCES-1:0]             MASK,
  input  logic                             ACK,
  output logic                             INTR,
  output logic [id_width(C_SOURCES)-1:0]   INTR_ID,
  output logic [C_SOURCES-1:0]             PENDING
);

  localparam int                ID_W       = id_width(C_SOURCES);
  // Reset points last_grant at the top source so source 0 wins first.
  localparam logic [ID_W-1:0]   LAST_RESET = ID_W'(C_SOURCES - 1);

  arb_state_e              state_q, state_d;
  logic                    intr_q, intr_d;
  logic [ID_W-1:0]         id_q, id_d;
  logic [ID_W-1:0]         last_q, last_d;
  logic [C_SOURCES-1:0]    pending;
  logic [C_SOURCES-1:0]    clr;
  logic [C_SOURCES-1:0]    eligible;
  logic [ID_W-1:0]         pick_id;
  logic                    found;
  int                      idx;

  for (genvar g = 0; g < C_SOURCES; g++) begin : g_src
    intr_source_capture #(
      .C_EDGE_DETECT (C_EDGE_DETECT),
      .C_ACTIVE      (C_ACTIVE)
    ) u_capture (
      .CLK     (CLK),
      .RST     (RST),
      .src     (SRC[g]),
      .clr     (clr[g]),
      .pending (pending[g])
    );
  end

  // Round-robin search starting one past the last granted source.
  always_comb begin
    eligible = pending & MASK;
    pick_id  = '0;
    found    = 1'b0;
    idx      = 0;
    for (int k = 1; k <= C_SOURCES; k++) begin
      idx = int'(last_q) + k;
      if (idx >= C_SOURCES) idx = idx - C_SOURCES;
      if (!found && eligible[idx]) begin
        found   = 1'b1;
        pick_id = ID_W'(idx);
      end
    end
  end

  // NOTE: every signal written here gets a default first, so no path
  // through the case leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    intr_d  = 1'b0;
    id_d    = id_q;
    last_d  = last_q;
    clr     = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (found) begin
          id_d    = pick_id;
          intr_d  = 1'b1;
          state_d = ST_ASSERT;
        end
      end
      ST_ASSERT: begin
        // Held regardless of MASK or a dropping level until acknowledged.
        intr_d = 1'b1;
        if (ACK) begin
          clr[id_q] = 1'b1;
          last_d    = id_q;
          intr_d    = 1'b0;
          state_d   = ST_GAP;
        end
      end
      ST_GAP:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: only the control flops are reset; there is no memory here, and
  // every register has a defined reset value.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      intr_q  <= 1'b0;
      id_q    <= '0;
      last_q  <= LAST_RESET;
    end else begin
      state_q <= state_d;
      intr_q  <= intr_d;
      id_q    <= id_d;
      last_q  <= last_d;
    end
  end

  assign INTR    = intr_q;
  assign INTR_ID = id_q;
  assign PENDING = pending;

endmodule

// File: doc/intr_arbiter.md
INTR_ARBITER -- requirements
Module: intr_arbiter

Interface
REQ-001 Parameter C_SOURCES, default 4: number of interrupt requesters; legal range 2..16.
REQ-002 Parameter C_EDGE_DETECT, default 1: 1 = rising-edge capture into pending; 0 = level (pending follows source).
REQ-003 Parameter C_ACTIVE, default 1: source polarity; 1 = active high, 0 = active low.
REQ-004 CLK  input  1  single clock; all logic on rising edge.
REQ-005 RST  input  1  synchronous, active-high reset.
REQ-006 SRC  input  C_SOURCES  interrupt requests; already synchronous to CLK.
REQ-007 MASK  input  C_SOURCES  1 = source enabled for arbitration.
REQ-008 ACK  input  1  one-cycle acknowledge of the currently presented interrupt.
REQ-009 INTR  output  1  merged interrupt line, active high.
REQ-010 INTR_ID  output  clog2(C_SOURCES)  index of the source being presented.
REQ-011 PENDING  output  C_SOURCES  raw pending bits, before masking.

Function
REQ-012 SRC shall be registered once (SRC_Q) after polarity normalisation; edge mode sets pending[i] when SRC_Q[i]=1 and previous SRC_Q[i]=0.
REQ-013 Level mode: pending[i] shall equal SRC_Q[i]; ACK shall not clear it.
REQ-014 FSM states: IDLE, ASSERT, GAP.
REQ-015 IDLE: if (pending & MASK) != 0, select the first set bit in round-robin order starting at last_grant+1 (wrapping), load INTR_ID, go to ASSERT; else stay.
REQ-016 ASSERT: INTR=1, INTR_ID stable; on ACK clear pending[INTR_ID] (edge mode), set last_grant=INTR_ID, go to GAP.
REQ-017 GAP: INTR=0 for exactly one cycle, then IDLE, guaranteeing a fresh rising edge for an edge-detecting consumer.
REQ-018 INTR shall be 1 only in ASSERT; registered output, no combinational path from SRC or ACK.
REQ-019 Latency: SRC active before edge 1 -> SRC_Q at edge 1 -> pending at edge 2 -> INTR=1 after edge 3 (3 cycles, idle arbiter).
REQ-020 Back-to-back: minimum INTR low time between two presentations is 2 cycles (GAP + IDLE).
REQ-021 ACK in IDLE or GAP shall be ignored, no state change.
REQ-022 Same-cycle new edge on source i and ACK clearing pending[i]: set wins, pending[i] remains 1.
REQ-023 Clearing MASK[INTR_ID] during ASSERT shall not withdraw INTR; presentation held until ACK.
REQ-024 Level mode: if SRC_Q[INTR_ID] drops during ASSERT, INTR stays asserted until ACK.
REQ-025 Masked sources shall still capture pending in edge mode; unmasking makes them eligible in the next IDLE cycle.
REQ-026 Repeated edges on an already-pending source shall coalesce into one pending bit.

Reset
REQ-027 RST shall force: state IDLE, INTR=0, INTR_ID=0, PENDING=0, SRC_Q=0, previous SRC_Q=0, last_grant=C_SOURCES-1 (source 0 wins first).
REQ-028 RST asserted mid-ASSERT shall drop INTR on the next edge and discard all pending bits; an SRC level held active through reset shall not generate an edge-mode event.

Structure
REQ-029 Package intr_arbiter_pkg shall hold the state enum (IDLE/ASSERT/GAP) and the ID-width function.
REQ-030 Sub-module intr_source_capture (per-source register, polarity, edge/level, pending set/clear) shall be instantiated C_SOURCES times via generate; arbitration and FSM stay in intr_arbiter.
REQ-031 Target size 150-300 lines of RTL total.

Verification
REQ-032 Reset, SRC=0001 pulse 1 cycle, MASK=1111 -> INTR=1 after edge 3, INTR_ID=0; ACK -> INTR=0 next cycle, PENDING=0000.
REQ-033 SRC=1111 pulsed together, ACK each presentation after 1 cycle -> INTR_ID sequence 0,1,2,3; INTR low 2 cycles between each.
REQ-034 MASK=1101, SRC[1] pulse -> PENDING=0010, INTR stays 0; set MASK=1111 -> INTR_ID=1 after 1 IDLE cycle.
REQ-035 Source 2 presented, new SRC[2] edge in ACK cycle -> PENDING[2]=1 after ACK; INTR_ID=2 presented again after GAP.
REQ-036 C_EDGE_DETECT=0, C_ACTIVE=0, SRC[3]=0 held -> INTR_ID=3; ACK with SRC[3] still 0 -> re-presented; SRC[3]=1 then ACK -> INTR stays 0.
REQ-037 RST pulse while INTR=1 with PENDING=0110 -> INTR=0, PENDING=0000 next cycle; SRC held active -> no new INTR in edge mode.
